// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the hazard-lights datapath.
//   wind_t is the wind-switch code used both by the input conditioner and by
//   the hazard-light FSM that consumes its w_out.
//   Contents:
//     wind_t        2-bit wind code (calm / right-to-left / left-to-right /
//                   illegal)
//     DEBOUNCE_MIN  smallest debounce length the conditioner accepts
// ----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    WIND_CALM    = 2'b00,
    WIND_R2L     = 2'b01,
    WIND_L2R     = 2'b10,
    WIND_ILLEGAL = 2'b11
  } wind_t;

  localparam int DEBOUNCE_MIN = 2;

endpackage : hazard_pkg

// File: rtl/wind_input_conditioner_bit_sync2.sv
// ----------------------------------------------------------------------------
// bit_sync2
//   Parameterised-width two-flop synchroniser. The second stage is fed
//   directly from the first with no logic in between, so the pair behaves as
//   a metastability filter with exactly two cycles of latency.
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   synchronous active-low reset (0 = reset), clears both stages
//     d      in   [WIDTH-1:0] asynchronous input
//     q      out  [WIDTH-1:0] synchronised output (second stage)
// ----------------------------------------------------------------------------
module bit_sync2 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1_reg;
  logic [WIDTH-1:0] stage2_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage1_reg <= '0;
      stage2_reg <= '0;
    end else begin
      stage1_reg <= d;
      stage2_reg <= stage1_reg;
    end
  end

  assign q = stage2_reg;

endmodule : bit_sync2

// File: rtl/wind_input_conditioner.sv
// ----------------------------------------------------------------------------
// wind_input_conditioner
//   Conditions the raw 2-bit wind switch code for the hazard-light FSM:
//   synchronises it, debounces it, commits stable codes to w_out and flags
//   the illegal code 11 (which is never passed on to w_out).
//   A new stable input first captured at edge E0 reaches w_out at edge
//   E0 + DEBOUNCE_CYCLES + 2.
//   Parameters:
//     DEBOUNCE_CYCLES  cycles a synchronised code must hold before commit
//                      (minimum DEBOUNCE_MIN, checked at elaboration)
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   synchronous active-low reset (0 = reset)
//     w_raw      in   [1:0] raw asynchronous wind switch code
//     w_out      out  [1:0] debounced, validated wind code
//     w_changed  out  one-cycle pulse when w_out takes a new, different value
//     illegal    out  one-cycle pulse when code 11 is committed
//     err        out  illegal-code status flag
//   Build option:
//     WIND_STICKY_ERR_EN  when defined, err stays set until reset; otherwise
//                         the next legal commit clears it.
// ----------------------------------------------------------------------------
module wind_input_conditioner
  import hazard_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] w_raw,
  output logic [1:0] w_out,
  output logic       w_changed,
  output logic       illegal,
  output logic       err
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit so an
  // illegal parameter still elaborates far enough to hit the check below.
  localparam int CNT_W_RAW = $clog2(DEBOUNCE_CYCLES);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < DEBOUNCE_MIN) begin : g_bad_debounce
      $error("wind_input_conditioner: DEBOUNCE_CYCLES=%0d is below %0d",
             DEBOUNCE_CYCLES, DEBOUNCE_MIN);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  logic [1:0] s;

  bit_sync2 #(
    .WIDTH (2)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (w_raw),
    .q     (s)
  );

  // --------------------------------------------------------------------------
  // Debounce / commit state
  // --------------------------------------------------------------------------
  wind_t            cand_reg,      cand_next;
  logic [CNT_W-1:0] cnt_reg,       cnt_next;
  logic             committed_reg, committed_next;
  wind_t            w_out_reg,     w_out_next;
  logic             w_changed_reg, w_changed_next;
  logic             illegal_reg,   illegal_next;
  logic             err_reg,       err_next;

  always_comb begin
    cand_next      = cand_reg;
    cnt_next       = cnt_reg;
    committed_next = committed_reg;
    w_out_next     = w_out_reg;
    w_changed_next = 1'b0;
    illegal_next   = 1'b0;
    err_next       = err_reg;

    if (s != cand_reg) begin
      // Any change of the synchronised code restarts the debounce window,
      // so short glitches never reach the commit branch.
      cand_next      = wind_t'(s);
      cnt_next       = '0;
      committed_next = 1'b0;
    end else if (!committed_reg && (cnt_reg == CNT_LAST)) begin
      // committed_reg makes a held code commit once per run, which is what
      // limits a held 11 to a single illegal pulse.
      committed_next = 1'b1;
      if (cand_reg == WIND_ILLEGAL) begin
        illegal_next = 1'b1;
        err_next     = 1'b1;
      end else begin
        w_out_next     = cand_reg;
        w_changed_next = (cand_reg != w_out_reg);
`ifdef WIND_STICKY_ERR_EN
        err_next = err_reg;
`else
        err_next = 1'b0;
`endif
      end
    end else if (!committed_reg) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // committed starts set so the reset code 00 is never "re-committed".
      cand_reg      <= WIND_CALM;
      cnt_reg       <= '0;
      committed_reg <= 1'b1;
      w_out_reg     <= WIND_CALM;
      w_changed_reg <= 1'b0;
      illegal_reg   <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      cand_reg      <= cand_next;
      cnt_reg       <= cnt_next;
      committed_reg <= committed_next;
      w_out_reg     <= w_out_next;
      w_changed_reg <= w_changed_next;
      illegal_reg   <= illegal_next;
      err_reg       <= err_next;
    end
  end

  assign w_out     = w_out_reg;
  assign w_changed = w_changed_reg;
  assign illegal   = illegal_reg;
  assign err       = err_reg;

endmodule : wind_input_conditioner

// File: tb/tb_wind_input_conditioner.sv
// ----------------------------------------------------------------------------
// tb_wind_input_conditioner
//   Self-checking bench for wind_input_conditioner (DEBOUNCE_CYCLES = 4).
//   A behavioural model tracks the input as a two-edge delay line feeding a
//   run-length detector: a synchronised value seen on DEBOUNCE_CYCLES+1
//   consecutive edges is committed once.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wind_input_conditioner;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] w_raw;
  logic [1:0] w_out;
  logic       w_changed;
  logic       illegal;
  logic       err;

  int checks = 0;
  int errors = 0;

  wind_input_conditioner #(
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .w_raw     (w_raw),
    .w_out     (w_out),
    .w_changed (w_changed),
    .illegal   (illegal),
    .err       (err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [1:0] dly_q[2];
  logic [1:0] run_val;
  int         run_len;
  bit         run_done;
  logic [1:0] m_w_out;
  logic       m_chg, m_ill, m_err;

  task automatic model_edge();
    logic [1:0] s;
    if (!reset) begin
      dly_q[0] = 2'b00; dly_q[1] = 2'b00;
      run_val = 2'b00; run_len = 0; run_done = 1'b1;
      m_w_out = 2'b00; m_chg = 1'b0; m_ill = 1'b0; m_err = 1'b0;
    end else begin
      s = dly_q[1];
      dly_q[1] = dly_q[0];
      dly_q[0] = w_raw;
      m_chg = 1'b0;
      m_ill = 1'b0;
      if (s == run_val) run_len++;
      else begin
        run_val = s; run_len = 1; run_done = 1'b0;
      end
      if (!run_done && run_len == DC + 1) begin
        run_done = 1'b1;
        if (run_val == 2'b11) begin
          m_ill = 1'b1;
          m_err = 1'b1;
        end else begin
          m_chg = (run_val != m_w_out);
          m_w_out = run_val;
`ifndef WIND_STICKY_ERR_EN
          m_err = 1'b0;
`endif
        end
      end
    end
  endtask

  // Advance one edge, update the model, then move off the edge for sampling.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; w_raw = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (w_out !== 2'b00 || w_changed !== 1'b0 || illegal !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got w_out=%b chg=%b ill=%b err=%b exp 00 0 0 0",
                 i, w_out, w_changed, illegal, err);
      end
    end
    reset = 1'b1; w_raw = 2'b00;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (w_out !== 2'b00 || w_changed !== 1'b0 || illegal !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got w_out=%b chg=%b ill=%b err=%b exp 00 0 0 0",
                 i, w_out, w_changed, illegal, err);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_latency();
    w_raw = 2'b01;
    for (int i = 0; i <= 8; i++) begin
      step();   // edge E0+i
      checks++;
      if (w_out !== m_w_out || w_changed !== m_chg || illegal !== m_ill || err !== m_err) begin
        errors++;
        $display("FAIL latency_model E0+%0d got %b %b %b %b exp %b %b %b %b",
                 i, w_out, w_changed, illegal, err, m_w_out, m_chg, m_ill, m_err);
      end
      if (i == DC + 1) begin
        checks++;
        if (w_out !== 2'b00) begin
          errors++;
          $display("FAIL latency_early E0+%0d got w_out=%b exp 00", i, w_out);
        end
      end
      if (i == DC + 2) begin
        checks++;
        if (w_out !== 2'b01 || w_changed !== 1'b1) begin
          errors++;
          $display("FAIL latency_commit E0+%0d got w_out=%b chg=%b exp 01 1", i, w_out, w_changed);
        end
      end
      if (i == DC + 3) begin
        checks++;
        if (w_changed !== 1'b0) begin
          errors++;
          $display("FAIL latency_pulse_width E0+%0d got chg=%b exp 0", i, w_changed);
        end
      end
    end
    $display("test_latency done");
  endtask

  task automatic test_glitch();
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      w_raw = (i < 2) ? 2'b10 : 2'b01;
      step();
      if (w_changed || illegal) pulses++;
      checks++;
      if (w_out !== m_w_out || w_changed !== m_chg || illegal !== m_ill || err !== m_err) begin
        errors++;
        $display("FAIL glitch_model cyc %0d got %b %b %b %b exp %b %b %b %b",
                 i, w_out, w_changed, illegal, err, m_w_out, m_chg, m_ill, m_err);
      end
      checks++;
      if (w_out !== 2'b01) begin
        errors++;
        $display("FAIL glitch_hold cyc %0d got w_out=%b exp 01", i, w_out);
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL glitch_pulses got %0d exp 0", pulses);
    end
    $display("test_glitch done");
  endtask

  task automatic test_illegal();
    int ill_cnt = 0;
    int chg_cnt = 0;
    w_raw = 2'b10;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (w_out !== 2'b10) begin
      errors++;
      $display("FAIL illegal_setup got w_out=%b exp 10", w_out);
    end
    w_raw = 2'b11;
    for (int i = 0; i < 12; i++) begin
      step();
      if (illegal) ill_cnt++;
      checks++;
      if (w_out !== m_w_out || w_changed !== m_chg || illegal !== m_ill || err !== m_err) begin
        errors++;
        $display("FAIL illegal_model E0+%0d got %b %b %b %b exp %b %b %b %b",
                 i, w_out, w_changed, illegal, err, m_w_out, m_chg, m_ill, m_err);
      end
      checks++;
      if (w_out !== 2'b10 || illegal !== (i == DC + 2) || err !== (i >= DC + 2)) begin
        errors++;
        $display("FAIL illegal_run E0+%0d got w_out=%b ill=%b err=%b", i, w_out, illegal, err);
      end
    end
    checks++;
    if (ill_cnt != 1) begin
      errors++;
      $display("FAIL illegal_count got %0d exp 1", ill_cnt);
    end
    w_raw = 2'b00;
    for (int i = 0; i < 8; i++) begin
      step();
      if (w_changed) chg_cnt++;
      checks++;
      if (w_out !== m_w_out || w_changed !== m_chg || illegal !== m_ill || err !== m_err) begin
        errors++;
        $display("FAIL illegal_recover_model cyc %0d got %b %b %b %b exp %b %b %b %b",
                 i, w_out, w_changed, illegal, err, m_w_out, m_chg, m_ill, m_err);
      end
    end
    checks++;
`ifdef WIND_STICKY_ERR_EN
    if (w_out !== 2'b00 || chg_cnt != 1 || err !== 1'b1) begin
`else
    if (w_out !== 2'b00 || chg_cnt != 1 || err !== 1'b0) begin
`endif
      errors++;
      $display("FAIL illegal_recover got w_out=%b chg_cnt=%0d err=%b", w_out, chg_cnt, err);
    end
    $display("test_illegal done");
  endtask

  task automatic test_reset_mid();
    w_raw = 2'b01;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    step();
    checks++;
    if (w_out !== 2'b00 || w_changed !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear got w_out=%b chg=%b err=%b exp 00 0 0", w_out, w_changed, err);
    end
    reset = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      step();   // i = 0 is the first edge with reset released
      checks++;
      if (w_out !== m_w_out || w_changed !== m_chg || illegal !== m_ill || err !== m_err) begin
        errors++;
        $display("FAIL reset_mid_model R+%0d got %b %b %b %b exp %b %b %b %b",
                 i, w_out, w_changed, illegal, err, m_w_out, m_chg, m_ill, m_err);
      end
      checks++;
      if (w_changed !== (i == DC + 2) || w_out !== ((i >= DC + 2) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL reset_mid_commit R+%0d got w_out=%b chg=%b", i, w_out, w_changed);
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_sweep();
    logic [1:0] seq[5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    int chg_cnt = 0;
    int ill_cnt = 0;
    reset = 1'b0; w_raw = 2'b00;
    step(); step();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      w_raw = seq[k];
      for (int i = 0; i < 8; i++) begin
        step();
        if (w_changed) chg_cnt++;
        if (illegal) ill_cnt++;
        checks++;
        if (w_out !== m_w_out || w_changed !== m_chg || illegal !== m_ill || err !== m_err) begin
          errors++;
          $display("FAIL sweep_model seg %0d cyc %0d got %b %b %b %b exp %b %b %b %b",
                   k, i, w_out, w_changed, illegal, err, m_w_out, m_chg, m_ill, m_err);
        end
        if (i == 7) begin
          checks++;
          if (w_out !== seq[k]) begin
            errors++;
            $display("FAIL sweep_follow seg %0d got w_out=%b exp %b", k, w_out, seq[k]);
          end
        end
      end
    end
    checks++;
    if (chg_cnt != 4 || ill_cnt != 0) begin
      errors++;
      $display("FAIL sweep_pulses got chg=%0d ill=%0d exp 4 0", chg_cnt, ill_cnt);
    end
    $display("test_sweep done");
  endtask

  task automatic test_random();
    int left = 0;
    for (int i = 0; i < 600; i++) begin
      if (left == 0) begin
        w_raw = 2'($urandom_range(0, 3));
        left  = $urandom_range(1, 9);
      end
      left--;
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      step();
      checks++;
      if (w_out !== m_w_out || w_changed !== m_chg || illegal !== m_ill || err !== m_err) begin
        errors++;
        $display("FAIL random_model cyc %0d raw=%b rst=%b got %b %b %b %b exp %b %b %b %b",
                 i, w_raw, reset, w_out, w_changed, illegal, err, m_w_out, m_chg, m_ill, m_err);
      end
    end
    reset = 1'b1;
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b0;
    w_raw = 2'b00;
    test_reset();
    test_latency();
    test_glitch();
    test_illegal();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_wind_input_conditioner
